// File: rtl/network_sequencer.sv
// -----------------------------------------------------------------------------
// network_sequencer
//
// Sequences one forward pass of an N_LAYERS-deep conv1d pipeline for every
// rising edge of an asynchronous sample-rate strobe. A pass shifts the input
// buffers, then for each layer resets/starts the conv block, waits for its
// output-valid, clocks the activation cache between layers, and finally
// latches the last layer's output. The block also keeps pass-length
// statistics, counts sample edges that arrive while a pass is in flight,
// and flags layers that never produce a result.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   sample_clk       asynchronous sample strobe; each rising edge requests a pass
//   conv_out_v       per-layer conv output-valid (bit i = layer i)
//   lsb_shift        one-cycle pulse clocking the input left-shift buffers
//   conv_rst         one-hot one-cycle pulse resetting/starting conv layer i
//   cache_shift      one-cycle pulse clocking the activation cache after layer i
//   out_latch        one-cycle pulse capturing the final conv output
//   busy             high while a pass is in progress
//   overrun          one-cycle pulse when a sample edge arrives while busy
//   overrun_count    saturating count of overrun events
//   last_pass_cycles cycle length of the most recent completed pass
//   max_pass_cycles  largest completed pass length since reset
//   timeout_err      sticky flag: some layer exceeded TIMEOUT wait cycles
// -----------------------------------------------------------------------------
module network_sequencer #(
    parameter int unsigned N_LAYERS = 3,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic [N_LAYERS-1:0] conv_out_v,
    output logic                lsb_shift,
    output logic [N_LAYERS-1:0] conv_rst,
    output logic [N_LAYERS-2:0] cache_shift,
    output logic                out_latch,
    output logic                busy,
    output logic                overrun,
    output logic [CNT_W-1:0]    overrun_count,
    output logic [CNT_W-1:0]    last_pass_cycles,
    output logic [CNT_W-1:0]    max_pass_cycles,
    output logic                timeout_err
);

    localparam int unsigned     LI_W     = $clog2(N_LAYERS);
    localparam int unsigned     WC_W     = $clog2(TIMEOUT + 1);
    localparam logic [LI_W-1:0] LAST_LI  = LI_W'(N_LAYERS - 1);
    localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        RST_CONV,
        WAIT_CONV,
        SHIFT_CACHE,
        LATCH_OUT
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [LI_W-1:0] li;
    logic [LI_W-1:0] li_next;
    logic [WC_W-1:0] wc;
    logic [WC_W-1:0] wc_next;
    logic            timeout_hit;

    logic            s1;
    logic            s2;
    logic            s3;
    logic            start;

    logic [CNT_W-1:0] pc;

    // Next-cycle values of the registered outputs
    logic                lsb_shift_d;
    logic [N_LAYERS-1:0] conv_rst_d;
    logic [N_LAYERS-2:0] cache_shift_d;
    logic                out_latch_d;
    logic                busy_d;

    // -------------------------------------------------------------------------
    // Sample strobe synchronizer: s1/s2 resolve metastability, s3 holds the
    // previous synchronized level so a rising edge yields a single start.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sample_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start = s2 & ~s3;

    // -------------------------------------------------------------------------
    // State register (with layer index and wait counter)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            li    <= '0;
            wc    <= '0;
        end else begin
            state <= state_next;
            li    <= li_next;
            wc    <= wc_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        li_next     = li;
        wc_next     = wc;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT_IN;
                    li_next    = '0;
                end
            end
            SHIFT_IN: begin
                state_next = RST_CONV;
            end
            RST_CONV: begin
                state_next = WAIT_CONV;
                wc_next    = '0;
            end
            WAIT_CONV: begin
                // Only the active layer's valid bit is looked at.
                if (conv_out_v[li]) begin
                    if (li < LAST_LI) begin
                        state_next = SHIFT_CACHE;
                    end else begin
                        state_next = LATCH_OUT;
                    end
                end else if (wc == WC_LIMIT) begin
                    // wc counts 0..TIMEOUT-1, so a stuck layer gets exactly
                    // TIMEOUT wait cycles before the pass is abandoned.
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end else begin
                    wc_next = wc + 1'b1;
                end
            end
            SHIFT_CACHE: begin
                state_next = RST_CONV;
                li_next    = li + 1'b1;
            end
            LATCH_OUT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode. Decoding from the next state lets the registered pulses
    // line up exactly with the state cycle they belong to.
    // -------------------------------------------------------------------------
    always_comb begin
        lsb_shift_d = (state_next == SHIFT_IN);
        out_latch_d = (state_next == LATCH_OUT);
        busy_d      = (state_next != IDLE);
        conv_rst_d  = '0;
        for (int unsigned i = 0; i < N_LAYERS; i++) begin
            conv_rst_d[i] = (state_next == RST_CONV) && (li_next == LI_W'(i));
        end
        cache_shift_d = '0;
        for (int unsigned i = 0; i < N_LAYERS - 1; i++) begin
            cache_shift_d[i] = (state_next == SHIFT_CACHE) && (li_next == LI_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsb_shift   <= 1'b0;
            conv_rst    <= '0;
            cache_shift <= '0;
            out_latch   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            lsb_shift   <= lsb_shift_d;
            conv_rst    <= conv_rst_d;
            cache_shift <= cache_shift_d;
            out_latch   <= out_latch_d;
            busy        <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Overrun detection, timeout flag and pass statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun          <= 1'b0;
            overrun_count    <= '0;
            timeout_err      <= 1'b0;
            pc               <= '0;
            last_pass_cycles <= '0;
            max_pass_cycles  <= '0;
        end else begin
            // A start seen in any non-IDLE state (LATCH_OUT included) is
            // dropped; IDLE is the only state that accepts it.
            overrun <= start && (state != IDLE);
            if (start && (state != IDLE) && (overrun_count != '1)) begin
                overrun_count <= overrun_count + 1'b1;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end

            // pc reads 1 during SHIFT_IN and equals the pass length in LATCH_OUT.
            if ((state == IDLE) && (state_next == SHIFT_IN)) begin
                pc <= CNT_W'(1);
            end else if ((state != IDLE) && (pc != '1)) begin
                pc <= pc + 1'b1;
            end

            if (state == LATCH_OUT) begin
                last_pass_cycles <= pc;
                if (pc > max_pass_cycles) begin
                    max_pass_cycles <= pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_network_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for network_sequencer (N_LAYERS=3, TIMEOUT=8).
// Stimulus pushes the expected pulse sequence, pass statistics and overrun
// counts into queues; an independent monitor pops and compares whenever the
// DUT presents a pulse. A behavioural conv responder raises conv_out_v[i] on
// a programmable WAIT_CONV cycle after conv_rst[i].
// -----------------------------------------------------------------------------
module tb_network_sequencer;

    localparam int N    = 3;
    localparam int TOUT = 8;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_clk = 1'b0;
    logic [N-1:0]  conv_out_v = '0;
    logic          lsb_shift;
    logic [N-1:0]  conv_rst;
    logic [N-2:0]  cache_shift;
    logic          out_latch;
    logic          busy;
    logic          overrun;
    logic [CW-1:0] overrun_count;
    logic [CW-1:0] last_pass_cycles;
    logic [CW-1:0] max_pass_cycles;
    logic          timeout_err;

    network_sequencer #(
        .N_LAYERS (N),
        .CNT_W    (CW),
        .TIMEOUT  (TOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_clk       (sample_clk),
        .conv_out_v       (conv_out_v),
        .lsb_shift        (lsb_shift),
        .conv_rst         (conv_rst),
        .cache_shift      (cache_shift),
        .out_latch        (out_latch),
        .busy             (busy),
        .overrun          (overrun),
        .overrun_count    (overrun_count),
        .last_pass_cycles (last_pass_cycles),
        .max_pass_cycles  (max_pass_cycles),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Event codes: 0 lsb_shift, 10+i conv_rst[i], 20+i cache_shift[i], 30 out_latch
    int exp_ev[$];
    int exp_last[$];
    int exp_max[$];
    int exp_ovr[$];

    int wait_cfg[N];   // WAIT_CONV cycle on which valid rises; 0 = never
    bit noise_cfg = 1'b0;

    task automatic check(input string nm, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Conv responder
    // ------------------------------------------------------------------------
    int k[N];
    bit armed[N];

    always @(negedge clk) begin
        if (!rst || !busy) begin
            for (int i = 0; i < N; i++) begin
                armed[i] = 1'b0;
                k[i] = 0;
            end
            conv_out_v = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (conv_rst[i]) begin
                    armed[i] = 1'b1;
                    k[i] = 0;
                    conv_out_v[i] = 1'b0;
                end else if (armed[i]) begin
                    k[i]++;
                    conv_out_v[i] = (wait_cfg[i] != 0) && (k[i] == wait_cfg[i]);
                    if ((wait_cfg[i] != 0) && (k[i] > wait_cfg[i])) armed[i] = 1'b0;
                end else begin
                    conv_out_v[i] = 1'b0;
                end
            end
            if (noise_cfg) begin
                for (int j = 0; j < N; j++) begin
                    if (armed[j] && wait_cfg[j] == 0) begin
                        for (int i = 0; i < N; i++) begin
                            if (i != j) conv_out_v[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    bit prev_latch = 1'b0;

    always @(negedge clk) begin
        int n;
        int code;
        if (!rst) begin
            prev_latch = 1'b0;
        end else begin
            if (prev_latch) begin
                if (exp_last.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pass_stats: got unexpected completed pass, want none");
                end else begin
                    check("last_pass_cycles", last_pass_cycles, exp_last.pop_front());
                    check("max_pass_cycles", max_pass_cycles, exp_max.pop_front());
                end
            end
            n = int'(lsb_shift) + $countones(conv_rst) + $countones(cache_shift) + int'(out_latch);
            if (n != 0) begin
                check("pulse_onehot", n, 1);
                code = -1;
                if (lsb_shift) code = 0;
                for (int i = 0; i < N; i++) if (conv_rst[i]) code = 10 + i;
                for (int i = 0; i < N - 1; i++) if (cache_shift[i]) code = 20 + i;
                if (out_latch) code = 30;
                if (exp_ev.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pulse_seq: got unexpected pulse code %0d, want none", code);
                end else begin
                    check("pulse_seq", code, exp_ev.pop_front());
                end
            end
            if (overrun) begin
                if (exp_ovr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL overrun: got unexpected overrun pulse, want none");
                end else begin
                    check("overrun_count", overrun_count, exp_ovr.pop_front());
                end
            end
            prev_latch = out_latch;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_full_pass(input int last, input int mx);
        exp_ev.push_back(0);
        for (int i = 0; i < N; i++) begin
            exp_ev.push_back(10 + i);
            if (i < N - 1) exp_ev.push_back(20 + i);
        end
        exp_ev.push_back(30);
        exp_last.push_back(last);
        exp_max.push_back(mx);
    endtask

    task automatic set_waits(input int w0, input int w1, input int w2);
        wait_cfg[0] = w0;
        wait_cfg[1] = w1;
        wait_cfg[2] = w2;
    endtask

    // Rising sample edge; returns with the pass already in SHIFT_IN.
    task automatic fire();
        @(negedge clk);
        sample_clk = 1'b1;
        tick(3);
        sample_clk = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, busy, 0);
    endtask

    task automatic wait_rst1(input string nm);
        int n = 0;
        while (!conv_rst[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(nm, conv_rst[1], 1);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        set_waits(3, 3, 3);
        #1 rst = 1'b0;
        tick(3);
        check("reset_pulses", {lsb_shift, conv_rst, cache_shift, out_latch, busy, overrun}, 0);
        check("reset_counters", overrun_count | last_pass_cycles | max_pass_cycles, 0);
        check("reset_timeout_err", timeout_err, 0);
        rst = 1'b1;
        tick(3);

        // Baseline pass, 3 wait cycles per layer, plus start latency
        push_full_pass(16, 16);
        @(negedge clk);
        sample_clk = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c < 3) check("latency_early", lsb_shift, 0);
            else       check("latency_edge_k2", lsb_shift, 1);
        end
        sample_clk = 1'b0;
        wait_idle("passA_idle");
        tick(3);
        check("passA_busy_after", busy, 0);

        // Second sample edge mid-pass is an overrun and is dropped
        push_full_pass(16, 16);
        exp_ovr.push_back(1);
        @(negedge clk);
        sample_clk = 1'b1;
        tick(2);
        sample_clk = 1'b0;
        tick(3);
        sample_clk = 1'b1;
        tick(3);
        sample_clk = 1'b0;
        wait_idle("passB_idle");
        tick(10);
        check("overrun_no_second_pass", busy, 0);
        check("overrun_count_final", overrun_count, 1);

        // Layer 1 never responds, other valid bits held high as noise
        set_waits(3, 0, 3);
        noise_cfg = 1'b1;
        exp_ev.push_back(0);
        exp_ev.push_back(10);
        exp_ev.push_back(20);
        exp_ev.push_back(11);
        fire();
        wait_rst1("timeout_saw_rst1");
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("timeout_wait_len", n, TOUT + 1);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_last_kept", last_pass_cycles, 16);
        check("timeout_max_kept", max_pass_cycles, 16);
        noise_cfg = 1'b0;
        tick(3);

        // Normal pass after a timeout; flag stays set
        set_waits(3, 3, 3);
        push_full_pass(16, 16);
        fire();
        wait_idle("passC_idle");
        tick(2);
        check("timeout_err_sticky", timeout_err, 1);

        // Short pass then a longer one
        set_waits(1, 1, 1);
        push_full_pass(10, 16);
        fire();
        wait_idle("passD_idle");
        tick(2);
        set_waits(4, 4, 4);
        push_full_pass(19, 19);
        fire();
        wait_idle("passE_idle");
        tick(2);

        // Reset during layer 1 wait aborts immediately
        set_waits(3, 3, 3);
        exp_ev.push_back(0);
        exp_ev.push_back(10);
        exp_ev.push_back(20);
        exp_ev.push_back(11);
        fire();
        wait_rst1("abort_saw_rst1");
        tick(1);
        #2 rst = 1'b0;
        #1;
        check("abort_pulses", {lsb_shift, conv_rst, cache_shift, out_latch, busy, overrun}, 0);
        check("abort_counters", overrun_count | last_pass_cycles | max_pass_cycles, 0);
        check("abort_timeout_err", timeout_err, 0);
        tick(2);
        rst = 1'b1;
        tick(20);
        check("abort_stays_idle", busy, 0);

        push_full_pass(16, 16);
        fire();
        wait_idle("passF_idle");
        tick(3);

        check("exp_ev_drained", exp_ev.size(), 0);
        check("exp_last_drained", exp_last.size(), 0);
        check("exp_ovr_drained", exp_ovr.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
